usr_sequencer: RTL and testbench

Command-driven controller that sequences the 4-bit universal shift register (mode-select mux plus negedge D-FF datapath). It accepts one command at a time over a valid/ready handshake: clear, parallel load, or N-step left/right shift with a serial bit stream. It drives the register's mode, serial, parallel and clear inputs, then returns the final register contents with a done pulse. It sits between a host or bus-side block and the shift register.

---
 rtl/usr_sequencer.sv | 130 +++++++++++++
 tb/tb_usr_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_sequencer.sv
// usr_sequencer: command-driven controller for the 4-bit universal shift
// register. Accepts CLEAR / SHIFT_UP / SHIFT_DN / LOAD over valid/ready,
// drives the register's mode/serial/parallel/clear inputs, then returns
// the register contents with a one-cycle done pulse.
module usr_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       sr_s,
  output logic             sr_d,
  output logic [WIDTH-1:0] sr_p,
  output logic             sr_clr,
  input  logic [WIDTH-1:0] sr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rsp_q
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_s;
  logic             r_d;
  logic [WIDTH-1:0] r_p;
  logic             r_clr;
  logic [WIDTH-1:0] r_rsp;
  logic             r_done;
  logic             r_ready;
  logic             r_busy;

  // Sequencer FSM with all register-facing and host-facing outputs registered.
  // LOAD and CLEAR reuse the RUN state with a step count of one. The register
  // samples on the negedge, so sr_q is already settled at the posedge that
  // leaves RUN and can be captured directly into rsp_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_s     <= 2'b00;
      r_d     <= 1'b0;
      r_p     <= '0;
      r_clr   <= 1'b0;
      r_rsp   <= '0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_clr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            case (cmd_op)
              OP_CLEAR: begin
                r_clr   <= 1'b1;
                r_cnt   <= CNT_W'(1);
                r_state <= S_RUN;
              end
              OP_LOAD: begin
                r_s     <= 2'b11;
                r_p     <= cmd_data;
                r_cnt   <= CNT_W'(1);
                r_state <= S_RUN;
              end
              default: begin
                if (cmd_cnt == '0) begin
                  // zero-step shift: nothing to drive, report current contents
                  r_rsp   <= sr_q;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_s     <= cmd_op;
                  r_d     <= cmd_data[0];
                  r_data  <= cmd_data >> 1;
                  r_cnt   <= cmd_cnt;
                  r_state <= S_RUN;
                end
              end
            endcase
          end
        end
        S_RUN: begin
          if (r_cnt == CNT_W'(1)) begin
            r_s     <= 2'b00;
            r_d     <= 1'b0;
            r_rsp   <= sr_q;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            // serial stream is zero-filled once the data word is exhausted
            r_cnt  <= r_cnt - CNT_W'(1);
            r_d    <= r_data[0];
            r_data <= r_data >> 1;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign sr_s      = r_s;
  assign sr_d      = r_d;
  assign sr_p      = r_p;
  assign sr_clr    = r_clr;
  assign done      = r_done;
  assign rsp_q     = r_rsp;

endmodule

// File: tb/tb_usr_sequencer.sv
// tb_usr_sequencer: randomized and directed checks of usr_sequencer against
// a command-level reference model, with a negedge shift register attached.
module tb_usr_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;
  logic [1:0]       sr_s;
  logic             sr_d;
  logic [WIDTH-1:0] sr_p;
  logic             sr_clr;
  logic [WIDTH-1:0] sr_q;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rsp_q;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] model_q = '0;
  logic [WIDTH-1:0] last_p  = '0;

  usr_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .sr_s(sr_s), .sr_d(sr_d), .sr_p(sr_p), .sr_clr(sr_clr), .sr_q(sr_q),
    .busy(busy), .done(done), .rsp_q(rsp_q)
  );

  always #5 clk = ~clk;

  // attached universal shift register, sampling on the negedge
  logic [WIDTH-1:0] reg_q = '0;
  always @(negedge clk) begin
    if (sr_clr) reg_q <= '0;
    else begin
      case (sr_s)
        2'b01:   reg_q <= {reg_q[WIDTH-2:0], sr_d};
        2'b10:   reg_q <= {sr_d, reg_q[WIDTH-1:1]};
        2'b11:   reg_q <= sr_p;
        default: reg_q <= reg_q;
      endcase
    end
  end
  assign sr_q = reg_q;

  // command-level reference: final register value after one command
  function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] op, input int cnt,
                                                  input logic [WIDTH-1:0] data,
                                                  input logic [WIDTH-1:0] prev);
    logic [WIDTH-1:0] q;
    logic b;
    q = prev;
    case (op)
      2'b00: q = '0;
      2'b11: q = data;
      default: begin
        for (int i = 0; i < cnt; i++) begin
          b = (i < WIDTH) ? data[i] : 1'b0;
          if (op == 2'b01) q = {q[WIDTH-2:0], b};
          else             q = {b, q[WIDTH-1:1]};
        end
      end
    endcase
    return q;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input int cnt, input logic [WIDTH-1:0] data,
                         input bit noise, input string name);
    int wait_n, done_k, exp_k, exp_n, n_nz, n_clr, bad_s, d_bad, rdy_bad;
    logic [WIDTH-1:0] exp_q;
    logic exp_d;
    bit is_shift;
    is_shift = (op == 2'b01) || (op == 2'b10);
    exp_q = ref_result(op, cnt, data, model_q);
    exp_k = is_shift ? ((cnt == 0) ? 1 : cnt + 1) : 2;
    exp_n = (op == 2'b00) ? 0 : (op == 2'b11) ? 1 : cnt;
    cmd_op = op; cmd_cnt = CNT_W'(cnt); cmd_data = data; cmd_valid = 1'b1;
    wait_n = 0;
    while (cmd_ready !== 1'b1 && wait_n < 20) begin
      @(posedge clk); #1; wait_n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: cmd_ready=%b, required 1", name, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (noise) begin
      cmd_op = 2'($urandom); cmd_cnt = CNT_W'($urandom); cmd_data = WIDTH'($urandom);
    end else cmd_valid = 1'b0;
    done_k = 0; n_nz = 0; n_clr = 0; bad_s = 0; d_bad = 0; rdy_bad = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy !== 1'b1 || cmd_ready !== 1'b0) rdy_bad++;
      if (sr_s !== 2'b00) begin
        n_nz++;
        if (sr_s !== op) bad_s++;
      end
      if (sr_clr === 1'b1) n_clr++;
      if (is_shift) begin
        exp_d = (k <= cnt && k - 1 < WIDTH) ? data[k-1] : 1'b0;
        if (sr_d !== exp_d) d_bad++;
      end
      if (noise) begin
        cmd_op = 2'($urandom); cmd_cnt = CNT_W'($urandom); cmd_data = WIDTH'($urandom);
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_k != exp_k) begin
      errors++; $display("FAIL %s done_cycle: got %0d, required %0d", name, done_k, exp_k);
    end
    checks++;
    if (rsp_q !== exp_q) begin
      errors++; $display("FAIL %s rsp_q: got %b, required %b", name, rsp_q, exp_q);
    end
    checks++;
    if (n_nz != exp_n || bad_s != 0) begin
      errors++;
      $display("FAIL %s sr_s: active cycles %0d (wrong mode %0d), required %0d", name, n_nz, bad_s, exp_n);
    end
    checks++;
    if (n_clr != ((op == 2'b00) ? 1 : 0)) begin
      errors++; $display("FAIL %s sr_clr: pulses %0d, required %0d", name, n_clr, (op == 2'b00) ? 1 : 0);
    end
    checks++;
    if (d_bad != 0) begin
      errors++; $display("FAIL %s sr_d: %0d wrong serial bits, required 0", name, d_bad);
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++; $display("FAIL %s busy_window: %0d cycles with ready/busy wrong, required 0", name, rdy_bad);
    end
    model_q = exp_q;
    if (op == 2'b11) last_p = data;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b ready=%b busy=%b, required 0 1 0", name, done, cmd_ready, busy);
    end
    checks++;
    if (sr_s !== 2'b00 || sr_d !== 1'b0 || sr_p !== last_p) begin
      errors++;
      $display("FAIL %s idle_outputs: sr_s=%b sr_d=%b sr_p=%b, required 00 0 %b", name, sr_s, sr_d, sr_p, last_p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_cnt = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sr_s !== 2'b00 || sr_d !== 1'b0 || sr_p !== '0 || sr_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset sr_outputs: s=%b d=%b p=%b clr=%b, required 00 0 0000 0", sr_s, sr_d, sr_p, sr_clr);
    end
    checks++;
    if (rsp_q !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset host_outputs: rsp_q=%b done=%b busy=%b, required 0000 0 0", rsp_q, done, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset cmd_ready: got %b, required 1", cmd_ready);
    end
    last_p = '0;
  endtask

  task automatic test_load();
    run_cmd(2'b11, 0, 4'b1100, 1'b0, "load_1100");
  endtask

  task automatic test_shift_up();
    run_cmd(2'b00, 0, 4'b0000, 1'b0, "clear_a");
    run_cmd(2'b01, 3, 4'b0101, 1'b0, "shup3_0101");
  endtask

  task automatic test_shift_dn();
    run_cmd(2'b00, 0, 4'b1111, 1'b0, "clear_b");
    run_cmd(2'b10, 4, 4'b1011, 1'b0, "shdn4_1011");
  endtask

  task automatic test_zero_fill();
    run_cmd(2'b11, 0, 4'b1111, 1'b0, "load_1111");
    run_cmd(2'b01, 7, 4'b0001, 1'b0, "shup7_0001");
    run_cmd(2'b11, 0, 4'b1010, 1'b0, "load_1010");
    run_cmd(2'b01, 0, 4'b0111, 1'b0, "shup0");
    run_cmd(2'b10, 0, 4'b0111, 1'b0, "shdn0");
  endtask

  task automatic test_back_to_back();
    run_cmd(2'b11, 0, 4'b1001, 1'b1, "b2b_load");
    run_cmd(2'b10, 2, 4'b0110, 1'b1, "b2b_shdn");
    run_cmd(2'b00, 5, 4'b1111, 1'b1, "b2b_clear");
    run_cmd(2'b01, 6, 4'b1101, 1'b1, "b2b_shup");
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    int n_done;
    cmd_op = 2'b01; cmd_cnt = CNT_W'(7); cmd_data = 4'b1011; cmd_valid = 1'b1;
    @(posedge clk); #1;           // accept at this edge (T)
    cmd_valid = 1'b0;
    @(posedge clk); #1;           // T+1
    rst = 1'b1;
    @(posedge clk); #1;           // T+2 sees rst
    checks++;
    if (sr_s !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || sr_d !== 1'b0) begin
      errors++;
      $display("FAIL abort outputs: sr_s=%b busy=%b done=%b sr_d=%b, required 00 0 0 0", sr_s, busy, done, sr_d);
    end
    rst = 1'b0;
    n_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done != 0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL abort no_done: done pulses %0d ready=%b, required 0 and 1", n_done, cmd_ready);
    end
    last_p = '0;
    run_cmd(2'b11, 0, 4'b0110, 1'b0, "abort_load_0110");
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int i = 0; i < 25; i++) begin
      op = 2'($urandom);
      run_cmd(op, int'($urandom_range(0, 7)), WIDTH'($urandom), 1'($urandom), "random");
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_up();
    test_shift_dn();
    test_zero_fill();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
